// File: rtl/decodificador_bcd_anho.sv
// Packed 2-digit BCD year to 7-bit binary: shift-add over 4 cycles (valid) or 3 cycles (illegal).
// listo is high only when idle; dato_valido while busy is dropped, never queued.
module decodificador_bcd_anho #(
    parameter int N        = 7,
    parameter int ANHO_MAX = 99,
    parameter int N_ERR    = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [7:0]       datos_bcd,
    input  logic             dato_valido,
    output logic             listo,
    output logic [N-1:0]     anho_bin,
    output logic             anho_valido,
    output logic             error_bcd,
    output logic [N_ERR-1:0] conteo_errores
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        CAPTURA = 3'd1,
        SUMA    = 3'd2,
        FIN     = 3'd3,
        ERROR   = 3'd4
    } estado_t;

    localparam logic [7:0] LIMITE = 8'(ANHO_MAX);

    estado_t          estado_q, estado_d;
    logic [3:0]       decenas_q, decenas_d;
    logic [3:0]       unidades_q, unidades_d;
    logic [N-1:0]     acc_q, acc_d;
    logic [N-1:0]     anho_bin_q, anho_bin_d;
    logic             anho_valido_q, anho_valido_d;
    logic             error_bcd_q, error_bcd_d;
    logic [N_ERR-1:0] conteo_q, conteo_d;

    logic [7:0] valor_decimal;
    logic       digito_ilegal;

    // The range check only bites if ANHO_MAX is lowered below 99.
    assign valor_decimal = ({4'd0, decenas_q} * 8'd10) + {4'd0, unidades_q};
    assign digito_ilegal = (decenas_q > 4'd9) || (unidades_q > 4'd9) || (valor_decimal > LIMITE);

    always_ff @(posedge clk) begin
        if (reset) begin
            estado_q      <= IDLE;
            decenas_q     <= '0;
            unidades_q    <= '0;
            acc_q         <= '0;
            anho_bin_q    <= '0;
            anho_valido_q <= 1'b0;
            error_bcd_q   <= 1'b0;
            conteo_q      <= '0;
        end else begin
            estado_q      <= estado_d;
            decenas_q     <= decenas_d;
            unidades_q    <= unidades_d;
            acc_q         <= acc_d;
            anho_bin_q    <= anho_bin_d;
            anho_valido_q <= anho_valido_d;
            error_bcd_q   <= error_bcd_d;
            conteo_q      <= conteo_d;
        end
    end

    always_comb begin
        estado_d      = estado_q;
        decenas_d     = decenas_q;
        unidades_d    = unidades_q;
        acc_d         = acc_q;
        anho_bin_d    = anho_bin_q;
        anho_valido_d = 1'b0;
        error_bcd_d   = 1'b0;
        conteo_d      = conteo_q;
        case (estado_q)
            IDLE: begin
                if (dato_valido) begin
                    decenas_d  = datos_bcd[7:4];
                    unidades_d = datos_bcd[3:0];
                    estado_d   = CAPTURA;
                end
            end
            CAPTURA: begin
                if (digito_ilegal) begin
                    estado_d = ERROR;
                end else begin
                    acc_d    = N'(decenas_q) << 3;
                    estado_d = SUMA;
                end
            end
            SUMA: begin
                // tens*10 = tens*8 (already in acc) + tens*2
                acc_d    = acc_q + (N'(decenas_q) << 1) + N'(unidades_q);
                estado_d = FIN;
            end
            FIN: begin
                anho_bin_d    = acc_q;
                anho_valido_d = 1'b1;
                estado_d      = IDLE;
            end
            ERROR: begin
                error_bcd_d = 1'b1;
                if (conteo_q != '1) begin
                    conteo_d = conteo_q + N_ERR'(1);
                end
                estado_d = IDLE;
            end
            default: estado_d = IDLE;
        endcase
    end

    assign listo          = (estado_q == IDLE);
    assign anho_bin       = anho_bin_q;
    assign anho_valido    = anho_valido_q;
    assign error_bcd      = error_bcd_q;
    assign conteo_errores = conteo_q;

endmodule

// File: tb/tb_decodificador_bcd_anho.sv
// Bench for decodificador_bcd_anho: directed boundary steps plus random words
// checked against a decimal-arithmetic reference model.
module tb_decodificador_bcd_anho;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] datos_bcd;
    logic       dato_valido;
    logic       listo;
    logic [6:0] anho_bin;
    logic       anho_valido;
    logic       error_bcd;
    logic [3:0] conteo_errores;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state
    int exp_anho = 0;
    int n_err    = 0;

    decodificador_bcd_anho dut (
        .clk            (clk),
        .reset          (reset),
        .datos_bcd      (datos_bcd),
        .dato_valido    (dato_valido),
        .listo          (listo),
        .anho_bin       (anho_bin),
        .anho_valido    (anho_valido),
        .error_bcd      (error_bcd),
        .conteo_errores (conteo_errores)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input int obs, input int expv);
        n_tests++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic int exp_conteo();
        return (n_err > 15) ? 15 : n_err;
    endfunction

    function automatic bit es_legal(input logic [7:0] w);
        return (w[7:4] <= 4'd9) && (w[3:0] <= 4'd9);
    endfunction

    function automatic int valor_decimal(input logic [7:0] w);
        return int'(w[7:4]) * 10 + int'(w[3:0]);
    endfunction

    // Called one step after an edge with listo high; returns at the point where
    // the result is visible, so a following call accepts back-to-back.
    task automatic convert(input logic [7:0] w, input bit hold_busy);
        bit legal;
        legal = es_legal(w);
        chk("listo_before_accept", int'(listo), 1);
        datos_bcd   = w;
        dato_valido = 1'b1;
        tick(); // E0
        dato_valido = hold_busy;
        datos_bcd   = 8'($urandom);
        chk("listo_E0", int'(listo), 0);
        chk("strobe_width_valido", int'(anho_valido), 0);
        chk("strobe_width_error", int'(error_bcd), 0);
        tick(); // E1
        datos_bcd = 8'($urandom);
        chk("listo_E1", int'(listo), 0);
        tick(); // E2
        datos_bcd = 8'($urandom);
        if (!legal) begin
            dato_valido = 1'b0;
            n_err++;
            chk("error_bcd_E2", int'(error_bcd), 1);
            chk("anho_valido_on_error", int'(anho_valido), 0);
            chk("listo_after_error", int'(listo), 1);
            chk("anho_bin_held_on_error", int'(anho_bin), exp_anho);
            chk("conteo_errores", int'(conteo_errores), exp_conteo());
            return;
        end
        chk("listo_E2", int'(listo), 0);
        chk("no_early_strobe", int'(anho_valido), 0);
        tick(); // E3
        dato_valido = 1'b0;
        exp_anho = valor_decimal(w);
        chk("anho_valido_E3", int'(anho_valido), 1);
        chk("error_bcd_E3", int'(error_bcd), 0);
        chk("anho_bin", int'(anho_bin), exp_anho);
        chk("listo_E3", int'(listo), 1);
        chk("conteo_unchanged", int'(conteo_errores), exp_conteo());
    endtask

    initial begin
        logic [7:0] w;

        // Reset with a word offered: must be ignored.
        reset       = 1'b1;
        dato_valido = 1'b1;
        datos_bcd   = 8'h42;
        tick();
        tick();
        chk("rst_anho_bin", int'(anho_bin), 0);
        chk("rst_anho_valido", int'(anho_valido), 0);
        chk("rst_error_bcd", int'(error_bcd), 0);
        chk("rst_conteo", int'(conteo_errores), 0);
        reset       = 1'b0;
        dato_valido = 1'b0;
        tick();
        chk("idle_listo", int'(listo), 1);
        chk("idle_anho_valido", int'(anho_valido), 0);
        chk("idle_anho_bin", int'(anho_bin), 0);
        tick();
        chk("idle_listo_2", int'(listo), 1);
        chk("idle_no_strobe", int'(anho_valido | error_bcd), 0);

        // Basic conversion, then an illegal word that must keep 27.
        convert(8'h27, 1'b0);
        tick();
        chk("strobe_one_cycle", int'(anho_valido), 0);
        convert(8'h3C, 1'b0);

        // Back-to-back accepts at the first listo cycle.
        convert(8'h99, 1'b0);
        convert(8'h00, 1'b0);
        tick();
        chk("strobe_one_cycle_00", int'(anho_valido), 0);

        // Illegal boundary words, then enough illegal words to saturate.
        convert(8'h9A, 1'b0);
        convert(8'hA0, 1'b0);
        convert(8'hFF, 1'b0);
        for (int i = 0; i < 20; i++) begin
            w = 8'($urandom);
            if (es_legal(w)) w[7:4] = 4'hA + 4'($urandom_range(0, 5));
            convert(w, 1'b0);
        end
        chk("conteo_saturated", int'(conteo_errores), 15);

        // Busy-time offers with changing data must be dropped.
        for (int i = 0; i < 8; i++) begin
            w = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            convert(w, 1'b1);
        end

        // Random mix with random idle gaps.
        for (int i = 0; i < 150; i++) begin
            w = 8'($urandom);
            if ($urandom_range(0, 3) != 0) w = {4'($urandom_range(0, 9)), 4'($urandom_range(0, 9))};
            convert(w, 1'($urandom_range(0, 1)));
            for (int g = 0; g < int'($urandom_range(0, 2)); g++) begin
                tick();
                chk("gap_no_strobe", int'(anho_valido | error_bcd), 0);
                chk("gap_anho_bin_held", int'(anho_bin), exp_anho);
            end
        end

        // Long idle: result held.
        for (int i = 0; i < 10; i++) tick();
        chk("anho_bin_held_long", int'(anho_bin), exp_anho);

        // Reset while the conversion sits in SUMA aborts it silently.
        datos_bcd   = 8'h58;
        dato_valido = 1'b1;
        tick(); // E0 -> CAPTURA
        dato_valido = 1'b0;
        tick(); // E1 -> SUMA
        reset = 1'b1;
        tick();
        reset    = 1'b0;
        exp_anho = 0;
        n_err    = 0;
        chk("abort_no_valido", int'(anho_valido), 0);
        chk("abort_anho_bin", int'(anho_bin), 0);
        chk("abort_conteo", int'(conteo_errores), 0);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("abort_quiet", int'(anho_valido | error_bcd), 0);
        end
        chk("abort_listo", int'(listo), 1);
        convert(8'h05, 1'b0);
        chk("post_abort_05", int'(anho_bin), 5);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
